stream_demux_1_to_4: RTL and testbench
======================================

// Module: stream_demux_1_to_4
// PURPOSE
//  Routes one valid/ready input stream to one of four output streams, chosen per beat by i_sel.
//  It is the write-side counterpart of the 4:1 data mux: the producer fans out to four consumers.
//  Each output channel has its own 2-entry FIFO, so a stalled consumer never blocks the others.
//  A per-channel wrapping beat counter is provided for debug and verification.
// PARAMETERS
//  WIDTH    32  data width of every stream
//  COUNT_W  16  width of each per-channel delivered-beat counter
// PORTS
//  i_clk      in   1          clock; all logic is on the rising edge
//  i_rst_n    in   1          reset, synchronous, active-low
//  i_data     in   WIDTH      input beat payload
//  i_sel      in   2          destination channel for this beat (0..3)
//  i_valid    in   1          input beat present
//  o_ready    out  1          block accepts this beat
//  o_data0    out  WIDTH      channel 0 head-of-FIFO data (o_data1..o_data3 are identical for ch1..3)
//  o_valid    out  4          o_valid[k]: channel k has a beat
//  i_ready    in   4          i_ready[k]: consumer k takes the beat
//  o_count0   out  COUNT_W    beats delivered on channel 0 (o_count1..o_count3 are identical for ch1..3)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at a clock edge): all FIFOs empty, o_valid=4'b0000, all o_count=0, o_data*=0.
//    In-flight beats are discarded. o_ready=0 while i_rst_n=0.
//  - o_ready = i_rst_n & ~full[i_sel]. It is combinational on i_sel and on FIFO state only.
//    It never depends on i_valid or i_ready.
//  - Accept when i_valid & o_ready. {i_data} is pushed into FIFO[i_sel]. The other FIFOs are unchanged.
//  - Per-channel FIFO: 2 entries, in-order, with a registered head output.
//    o_valid[k] = ~empty[k]. o_data_k = head entry, and it holds stable while o_valid[k] & ~i_ready[k].
//    o_data_k holds its last value when the FIFO is empty.
//  - Latency: a beat accepted at edge N is visible on o_valid/o_data of its channel after edge N (1 cycle).
//    There is no combinational input-to-output path.
//  - Pop when o_valid[k] & i_ready[k]. o_count_k increments by 1, wrapping 2^COUNT_W-1 -> 0.
//  - Simultaneous push and pop on the same channel:
//    - count 1: count stays 1 and the new beat becomes the head.
//    - count 2: the push is already blocked by o_ready=0, even if a pop happens that cycle.
//      There is no same-cycle full bypass.
//  - Four channels may pop in the same cycle, independently. Push and pops to different channels are independent.
//  - i_sel and i_data are ignored when i_valid=0.
//  - Upstream rule: i_valid stays asserted with stable i_data/i_sel until accepted.
//  - Throughput: 1 beat/cycle into any channel whose consumer holds i_ready=1.
// TESTING
//  1 Reset: assert i_rst_n=0 for 2 clk with i_valid=1 -> o_ready=0, o_valid=0000, counts=0.
//  2 Round-robin: send 0xA0..0xA3 with sel 0,1,2,3, all i_ready=1.
//    -> each channel shows its beat 1 cycle later, and counts = 1 each.
//  3 Backpressure: i_ready[2]=0, send 3 beats to sel=2 (0x11, 0x22, 0x33).
//    -> o_ready=0 on the 3rd beat. Then raise i_ready[2]: 0x11 then 0x22 come out, and 0x33 is accepted afterwards.
//  4 Isolation: channel 1 full and stalled; sends to sel=3 -> accepted every cycle and delivered in order.
//  5 Push+pop: channel 0 holds 1 beat, i_ready[0]=1, push 0x55 the same cycle
//    -> 0x55 is the next head and o_valid[0] stays 1.
//  6 Wrap and mid-reset: COUNT_W=4, deliver 17 beats on ch0 -> o_count0=1.
//    Then reset with FIFOs non-empty -> all FIFOs empty on the next cycle.

Source files
------------

// File: rtl/stream_demux_1_to_4_if.sv
// Stream bundle for the 1:4 demux: one producer-side stream in,
// four consumer-side streams and their delivered-beat counters out.
interface stream_demux_1_to_4_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
);
    logic [WIDTH-1:0]   i_data;
    logic [1:0]         i_sel;
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   o_data0;
    logic [WIDTH-1:0]   o_data1;
    logic [WIDTH-1:0]   o_data2;
    logic [WIDTH-1:0]   o_data3;
    logic [3:0]         o_valid;
    logic [3:0]         i_ready;
    logic [COUNT_W-1:0] o_count0;
    logic [COUNT_W-1:0] o_count1;
    logic [COUNT_W-1:0] o_count2;
    logic [COUNT_W-1:0] o_count3;

    modport master (
        output i_data, i_sel, i_valid, i_ready,
        input  o_ready, o_valid,
        input  o_data0, o_data1, o_data2, o_data3,
        input  o_count0, o_count1, o_count2, o_count3
    );

    modport slave (
        input  i_data, i_sel, i_valid, i_ready,
        output o_ready, o_valid,
        output o_data0, o_data1, o_data2, o_data3,
        output o_count0, o_count1, o_count2, o_count3
    );
endinterface

// File: rtl/stream_demux_1_to_4.sv
// 1:4 valid/ready stream demux with a 2-entry FIFO and a
// wrapping delivered-beat counter on every output channel.
module stream_demux_1_to_4 #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    stream_demux_1_to_4_if.slave bus
);
    logic [WIDTH-1:0]   head_q [4];
    logic [WIDTH-1:0]   head_d [4];
    logic [WIDTH-1:0]   tail_q [4];
    logic [WIDTH-1:0]   tail_d [4];
    logic [1:0]         fill_q [4];
    logic [1:0]         fill_d [4];
    logic [COUNT_W-1:0] cnt_q  [4];
    logic [COUNT_W-1:0] cnt_d  [4];
    logic [3:0]         full;
    logic [3:0]         push;
    logic [3:0]         pop;
    logic               ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            full[k] = (fill_q[k] == 2'd2);
        end
    end

    // Full check only: no same-cycle bypass when the channel is draining.
    assign ready = i_rst_n & ~full[bus.i_sel];
    assign bus.o_ready = ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            push[k] = bus.i_valid & ready & (bus.i_sel == 2'(k));
            pop[k]  = (fill_q[k] != 2'd0) & bus.i_ready[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            head_d[k] = head_q[k];
            tail_d[k] = tail_q[k];
            fill_d[k] = fill_q[k];
            cnt_d[k]  = cnt_q[k];
            unique case ({push[k], pop[k]})
                2'b10: begin
                    if (fill_q[k] == 2'd0) begin
                        head_d[k] = bus.i_data;
                        fill_d[k] = 2'd1;
                    end else begin
                        tail_d[k] = bus.i_data;
                        fill_d[k] = 2'd2;
                    end
                end
                2'b01: begin
                    // Head keeps its value when the FIFO drains empty.
                    if (fill_q[k] == 2'd2) begin
                        head_d[k] = tail_q[k];
                    end
                    fill_d[k] = fill_q[k] - 2'd1;
                    cnt_d[k]  = cnt_q[k] + 1'b1;
                end
                2'b11: begin
                    head_d[k] = bus.i_data;
                    cnt_d[k]  = cnt_q[k] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                fill_q[k] <= 2'd0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                head_q[k] <= head_d[k];
                tail_q[k] <= tail_d[k];
                fill_q[k] <= fill_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bus.o_valid[k] = (fill_q[k] != 2'd0);
        end
    end

    assign bus.o_data0  = head_q[0];
    assign bus.o_data1  = head_q[1];
    assign bus.o_data2  = head_q[2];
    assign bus.o_data3  = head_q[3];
    assign bus.o_count0 = cnt_q[0];
    assign bus.o_count1 = cnt_q[1];
    assign bus.o_count2 = cnt_q[2];
    assign bus.o_count3 = cnt_q[3];
endmodule

// File: tb/tb_stream_demux_1_to_4.sv
// Bench for stream_demux_1_to_4: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_stream_demux_1_to_4;
    localparam int W  = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;

    stream_demux_1_to_4_if #(.WIDTH(W), .COUNT_W(CW)) ifc ();

    stream_demux_1_to_4 #(.WIDTH(W), .COUNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  dq [4];
    logic [CW-1:0] cq [4];
    assign dq[0] = ifc.o_data0;
    assign dq[1] = ifc.o_data1;
    assign dq[2] = ifc.o_data2;
    assign dq[3] = ifc.o_data3;
    assign cq[0] = ifc.o_count0;
    assign cq[1] = ifc.o_count1;
    assign cq[2] = ifc.o_count2;
    assign cq[3] = ifc.o_count3;

    // Reference model: per-channel queue, delivered count, last shown data.
    logic [W-1:0] mq [4][$];
    int unsigned  mcnt [4];
    logic [W-1:0] mlast [4];
    bit           mvalid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic exp_rdy;
        exp_rdy = rst_n && (mq[ifc.i_sel].size() < 2);
        chk("o_ready", 64'(ifc.o_ready), 64'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("o_valid%0d", k), 64'(ifc.o_valid[k]),
                64'(mq[k].size() != 0));
            chk($sformatf("o_data%0d", k), 64'(dq[k]),
                64'(mq[k].size() != 0 ? mq[k][0] : mlast[k]));
            chk($sformatf("o_count%0d", k), 64'(cq[k]), 64'(mcnt[k]));
        end
    endtask

    task automatic cycle(output bit acc);
        bit a;
        @(negedge clk);
        if (mvalid) compare();
        a = rst_n && ifc.i_valid && (mq[ifc.i_sel].size() < 2);
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mcnt[k]  = 0;
                mlast[k] = '0;
            end
            mvalid = 1'b1;
            a = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && ifc.i_ready[k]) begin
                    mlast[k] = mq[k].pop_front();
                    mcnt[k]  = (mcnt[k] + 1) % (1 << CW);
                end
            end
            if (a) mq[ifc.i_sel].push_back(ifc.i_data);
        end
        acc = a;
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        bit a;
        a = 1'b0;
        ifc.i_valid = 1'b1;
        ifc.i_sel   = s;
        ifc.i_data  = d;
        for (int i = 0; i < 20; i++) begin
            cycle(a);
            if (a) break;
        end
        chk("send_accept", 64'(a), 64'd1);
        ifc.i_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        rst_n       = 1'b0;
        ifc.i_valid = 1'b1;
        ifc.i_sel   = 2'd0;
        ifc.i_data  = 32'hDEAD_BEEF;
        ifc.i_ready = 4'h0;

        // Reset with a beat on offer.
        cycle(a);
        cycle(a);
        chk("rst_ready", 64'(ifc.o_ready), 64'd0);
        chk("rst_valid", 64'(ifc.o_valid), 64'd0);
        chk("rst_count0", 64'(ifc.o_count0), 64'd0);
        chk("rst_data0", 64'(ifc.o_data0), 64'd0);
        rst_n       = 1'b1;
        ifc.i_valid = 1'b0;
        cycle(a);

        // Round-robin.
        ifc.i_ready = 4'hF;
        for (int k = 0; k < 4; k++) send(2'(k), 32'hA0 + 32'(k));
        cycle(a);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_data%0d", k), 64'(dq[k]), 64'hA0 + 64'(k));
            chk($sformatf("rr_count%0d", k), 64'(cq[k]), 64'd1);
        end
        chk("rr_valid", 64'(ifc.o_valid), 64'd0);

        // Backpressure on channel 2.
        ifc.i_ready = 4'b1011;
        send(2'd2, 32'h11);
        send(2'd2, 32'h22);
        ifc.i_valid = 1'b1;
        ifc.i_sel   = 2'd2;
        ifc.i_data  = 32'h33;
        #1;
        chk("bp_full_ready", 64'(ifc.o_ready), 64'd0);
        chk("bp_head", 64'(ifc.o_data2), 64'h11);
        ifc.i_ready = 4'hF;
        cycle(a);
        chk("bp_no_bypass", 64'(a), 64'd0);
        chk("bp_head2", 64'(ifc.o_data2), 64'h22);
        cycle(a);
        chk("bp_accept3", 64'(a), 64'd1);
        chk("bp_head3", 64'(ifc.o_data2), 64'h33);
        ifc.i_valid = 1'b0;
        cycle(a);

        // Isolation: channel 1 full and stalled, channel 3 streams.
        ifc.i_ready = 4'b1101;
        send(2'd1, 32'h101);
        send(2'd1, 32'h102);
        for (int i = 0; i < 6; i++) begin
            ifc.i_valid = 1'b1;
            ifc.i_sel   = 2'd3;
            ifc.i_data  = 32'h300 + 32'(i);
            cycle(a);
            chk("iso_accept", 64'(a), 64'd1);
        end
        ifc.i_valid = 1'b0;
        chk("iso_ch1_head", 64'(ifc.o_data1), 64'h101);
        ifc.i_ready = 4'hF;
        repeat (3) cycle(a);

        // Push and pop together on a 1-entry channel.
        ifc.i_ready = 4'b1110;
        send(2'd0, 32'h44);
        chk("pp_head_before", 64'(ifc.o_data0), 64'h44);
        ifc.i_ready = 4'hF;
        ifc.i_valid = 1'b1;
        ifc.i_sel   = 2'd0;
        ifc.i_data  = 32'h55;
        cycle(a);
        chk("pp_accept", 64'(a), 64'd1);
        chk("pp_valid0", 64'(ifc.o_valid[0]), 64'd1);
        chk("pp_head", 64'(ifc.o_data0), 64'h55);
        ifc.i_valid = 1'b0;
        cycle(a);

        // Counter wrap, then reset with non-empty FIFOs.
        rst_n = 1'b0;
        cycle(a);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) send(2'd0, 32'h600 + 32'(i));
        cycle(a);
        chk("wrap_count0", 64'(ifc.o_count0), 64'd1);
        ifc.i_ready = 4'h0;
        send(2'd1, 32'h71);
        send(2'd2, 32'h72);
        send(2'd2, 32'h73);
        chk("pre_rst_valid", 64'(ifc.o_valid), 64'b0110);
        rst_n = 1'b0;
        cycle(a);
        chk("mid_rst_valid", 64'(ifc.o_valid), 64'd0);
        chk("mid_rst_count0", 64'(ifc.o_count0), 64'd0);
        rst_n = 1'b1;
        cycle(a);

        // Random traffic honouring the hold-until-accepted rule.
        a = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ifc.i_valid || a) begin
                ifc.i_valid = ($urandom_range(0, 3) != 0);
                ifc.i_sel   = 2'($urandom_range(0, 3));
                ifc.i_data  = $urandom;
            end
            ifc.i_ready = 4'($urandom) | 4'($urandom);
            if (n % 500 > 250) ifc.i_ready = 4'($urandom) & 4'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle(a);
        end
        rst_n = 1'b1;
        cycle(a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
